bennett_phase_seq: RTL

BENNETT_PHASE_SEQ -- requirements
Module: bennett_phase_seq

---
 rtl/bennett_pkg.sv | 6 +
 rtl/bennett_hold_timer.sv | 19 +
 rtl/bennett_phase_seq.sv | 98 +++++++++
 3 files changed

// File: rtl/bennett_pkg.sv
// bennett_pkg: shared state encoding and default geometry for the Bennett phase sequencer.
package bennett_pkg;
    localparam int BENNETT_WIDTH_DEF = 8;
    localparam int BENNETT_HOLD_DEF  = 1;
    typedef enum logic [1:0] {ST_IDLE, ST_RAMP_UP, ST_HOLD, ST_RAMP_DOWN} bennett_state_e;
endpackage

// File: rtl/bennett_hold_timer.sv
// bennett_hold_timer: down-counter measuring the HOLD evaluation window.
module bennett_hold_timer #(
    parameter int HOLD = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic tick,
    output logic done
);
    localparam int CW = $clog2(HOLD + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // Loaded with HOLD-1 so done rises in the last cycle of the window.
    always_comb cnt_d = load ? CW'(HOLD - 1) : (tick && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    assign done = (cnt_q == '0);
endmodule

// File: rtl/bennett_phase_seq.sv
// bennett_phase_seq: thermometer-coded Bennett clock phase sequencer.
// Define BENNETT_STRETCH_EN to add the stretch input that extends the HOLD phase.
module bennett_phase_seq
    import bennett_pkg::*;
#(
    parameter int WIDTH = BENNETT_WIDTH_DEF,
    parameter int HOLD  = BENNETT_HOLD_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef BENNETT_STRETCH_EN
    input  logic             stretch,
`endif
    output logic             ready,
    output logic             valid,
    output logic             instFlag,
    output logic [WIDTH-1:0] clkp,
    output logic [WIDTH-1:0] clkn
);
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "bennett_phase_seq: WIDTH must be 2..32");
    end
    if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
        $fatal(1, "bennett_phase_seq: HOLD must be 1..255");
    end

    bennett_state_e   state_q, state_d;
    logic [WIDTH-1:0] clkp_q, clkp_d, clkn_q, clkn_d;
    logic             valid_q, valid_d, inst_q, inst_d;
    logic             load, tick, done, hold_ext;

`ifdef BENNETT_STRETCH_EN
    assign hold_ext = stretch;
`else
    assign hold_ext = 1'b0;
`endif

    bennett_hold_timer #(.HOLD(HOLD)) u_hold (
        .clk(clk), .reset(reset), .load(load), .tick(tick), .done(done)
    );

    always_comb begin
        state_d = state_q;
        clkp_d  = clkp_q;
        inst_d  = 1'b0;
        load    = 1'b0;
        tick    = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                clkp_d  = WIDTH'(1);
                state_d = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                clkp_d = {clkp_q[WIDTH-2:0], 1'b1};
                if (clkp_q[WIDTH-2]) begin
                    state_d = ST_HOLD;
                    load    = 1'b1;
                end
            end
            ST_HOLD: if (done && !hold_ext) begin
                clkp_d  = clkp_q >> 1;
                state_d = ST_RAMP_DOWN;
            end else tick = 1'b1;
            ST_RAMP_DOWN: begin
                clkp_d = clkp_q >> 1;
                if (!clkp_q[1]) begin
                    state_d = ST_IDLE;
                    inst_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_HOLD);
        clkn_d  = ~clkp_d;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= ST_IDLE;
            clkp_q  <= '0;
            clkn_q  <= '1;
            valid_q <= 1'b0;
            inst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clkp_q  <= clkp_d;
            clkn_q  <= clkn_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
        end

    assign ready    = (state_q == ST_IDLE);
    assign valid    = valid_q;
    assign instFlag = inst_q;
    assign clkp     = clkp_q;
    assign clkn     = clkn_q;
endmodule
